sumador_restador_serie: RTL and testbench

Parametrised multi-cycle signed/unsigned adder-subtractor. It processes DIGIT bits per clock through a ripple slice, so area and latency trade off via parameters. Subtraction uses two's complement (invert B, carry-in 1). The block adds carry, signed overflow and zero flags, and a start/ready/valid handshake. It sits in the ALU datapath as the successor to the fixed-width combinational subtractor.

---
 rtl/sumador_restador_serie_pkg.sv | 21 ++
 rtl/sumador_restador_serie_if.sv | 26 ++
 rtl/sumador_restador_serie_digito.sv | 24 ++
 rtl/sumador_restador_serie.sv | 147 ++++++++++++++
 tb/tb_sumador_restador_serie.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/sumador_restador_serie_pkg.sv
// Shared constants for the serial adder-subtractor: FSM state encodings,
// operation mode codes and the packed status-flag record.
package sumador_restador_serie_pkg;

   // FSM state encodings
   localparam logic [1:0] EST_IDLE = 2'd0;
   localparam logic [1:0] EST_CALC = 2'd1;
   localparam logic [1:0] EST_DONE = 2'd2;

   // Operation select values for modo
   localparam logic MODO_SUMA  = 1'b0;
   localparam logic MODO_RESTA = 1'b1;

   // Status flags published alongside the result
   typedef struct packed {
      logic cOut;
      logic overflow;
      logic zero;
   } flags_t;

endpackage

// File: rtl/sumador_restador_serie_if.sv
// Request/response bundle of the serial adder-subtractor.
// master = requester (drives operands and start), slave = the arithmetic unit.
interface sumador_restador_serie_if #(parameter int WIDTH = 8);

   logic             start;
   logic             modo;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             valid;
   logic [WIDTH-1:0] resultado;
   logic             c_out;
   logic             overflow;
   logic             zero;

   modport master (
      output start, modo, a, b,
      input  ready, valid, resultado, c_out, overflow, zero
   );

   modport slave (
      input  start, modo, a, b,
      output ready, valid, resultado, c_out, overflow, zero
   );

endinterface

// File: rtl/sumador_restador_serie_digito.sv
// DIGIT-wide ripple-carry slice. c_msb is the carry entering the top bit,
// which the parent uses on the last digit to derive signed overflow.
module sumador_digito #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] suma;

   // Add the slice; the carry into the top bit is recovered from sum XOR operands
   always_comb begin
      suma  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
      s     = suma[DIGIT-1:0];
      co    = suma[DIGIT];
      c_msb = suma[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
   end

endmodule

// File: rtl/sumador_restador_serie.sv
// Multi-cycle signed/unsigned adder-subtractor, DIGIT bits per clock.
// Subtraction is A + ~B + 1. Optional macro SUMRES_SATURACION_EN clamps the
// result to the signed limit when overflow is detected.
module sumador_restador_serie
   import sumador_restador_serie_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sumador_restador_serie_if.slave bus
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

   logic [1:0]       estado_q, estado_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic             cMsb_q, cMsb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   flags_t           flags_q, flags_d;
   logic             valid_q, valid_d;

   logic [DIGIT-1:0] sliceS;
   logic             sliceCo;
   logic             sliceCmsb;
   logic [WIDTH-1:0] sliceExt;
   logic             ovfFinal;
   logic [WIDTH-1:0] resFinal;

   sumador_digito #(.DIGIT(DIGIT)) uDigito (
      .a     (opA_q[DIGIT-1:0]),
      .b     (opB_q[DIGIT-1:0]),
      .ci    (carry_q),
      .s     (sliceS),
      .co    (sliceCo),
      .c_msb (sliceCmsb)
   );

   // Widen the slice sum so it can be merged into the accumulator MSB end
   always_comb begin
      sliceExt              = '0;
      sliceExt[DIGIT-1:0]   = sliceS;
   end

   // Final result and overflow, with optional clamp to the signed limit
   always_comb begin
      ovfFinal = cMsb_q ^ carry_q;
      resFinal = acc_q;
`ifdef SUMRES_SATURACION_EN
      if (ovfFinal) begin
         resFinal = acc_q[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                   : {1'b1, {(WIDTH-1){1'b0}}};
      end
`endif
   end

   // Control FSM: latch operands, shift one digit per cycle, publish result
   always_comb begin
      estado_d = estado_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      cMsb_d   = cMsb_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      flags_d  = flags_q;
      valid_d  = 1'b0;
      case (estado_q)
         EST_IDLE: begin
            if (bus.start) begin
               opA_d    = bus.a;
               opB_d    = (bus.modo == MODO_RESTA) ? ~bus.b : bus.b;
               carry_d  = (bus.modo == MODO_RESTA);
               cMsb_d   = 1'b0;
               acc_d    = '0;
               cnt_d    = '0;
               estado_d = EST_CALC;
            end
         end
         EST_CALC: begin
            opA_d   = opA_q >> DIGIT;
            opB_d   = opB_q >> DIGIT;
            acc_d   = (acc_q >> DIGIT) | (sliceExt << (WIDTH - DIGIT));
            carry_d = sliceCo;
            cMsb_d  = sliceCmsb;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               estado_d = EST_DONE;
            end
         end
         EST_DONE: begin
            res_d            = resFinal;
            flags_d.cOut     = carry_q;
            flags_d.overflow = ovfFinal;
            flags_d.zero     = (resFinal == '0);
            valid_d          = 1'b1;
            estado_d         = EST_IDLE;
         end
         default: begin
            estado_d = EST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q <= EST_IDLE;
         opA_q    <= '0;
         opB_q    <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         cMsb_q   <= 1'b0;
         cnt_q    <= '0;
         res_q    <= '0;
         flags_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         cMsb_q   <= cMsb_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         flags_q  <= flags_d;
         valid_q  <= valid_d;
      end
   end

   assign bus.ready     = (estado_q == EST_IDLE);
   assign bus.valid     = valid_q;
   assign bus.resultado = res_q;
   assign bus.c_out     = flags_q.cOut;
   assign bus.overflow  = flags_q.overflow;
   assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Testbench for sumador_restador_serie: an 8-bit/1-digit and a 16-bit/4-digit
// instance checked against an arithmetic reference model.
module tb_sumador_restador_serie;
   import sumador_restador_serie_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   sumador_restador_serie_if #(.WIDTH(8))  if8 ();
   sumador_restador_serie_if #(.WIDTH(16)) if16 ();

   sumador_restador_serie #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8)
   );

   sumador_restador_serie #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values
   function automatic void refModel(input int w, input logic m,
                                    input longint ua, input longint ub,
                                    output logic [15:0] res, output logic co,
                                    output logic ov, output logic z);
      longint modv, half, sa, sb, sr, raw, r;
      modv = longint'(1) << w;
      half = modv / 2;
      sa   = (ua >= half) ? ua - modv : ua;
      sb   = (ub >= half) ? ub - modv : ub;
      if (m == MODO_RESTA) begin
         raw = ua - ub;
         sr  = sa - sb;
         co  = (ua >= ub);
      end else begin
         raw = ua + ub;
         sr  = sa + sb;
         co  = (raw >= modv);
      end
      r  = ((raw % modv) + modv) % modv;
      ov = (sr > half - 1) || (sr < -half);
`ifdef SUMRES_SATURACION_EN
      if (ov) r = (sr > 0) ? half - 1 : half;
`endif
      res = r[15:0];
      z   = (r == 0);
   endfunction

   task automatic drive(input int sel, input logic st, input logic m,
                        input logic [15:0] va, input logic [15:0] vb);
      if (sel == 0) begin
         if8.start = st;
         if8.modo  = m;
         if8.a     = va[7:0];
         if8.b     = vb[7:0];
      end else begin
         if16.start = st;
         if16.modo  = m;
         if16.a     = va;
         if16.b     = vb;
      end
   endtask

   task automatic sampleOut(input int sel, output logic rdy, output logic v,
                            output logic [15:0] r, output logic co,
                            output logic ov, output logic z);
      if (sel == 0) begin
         rdy = if8.ready;    v  = if8.valid;    r = {8'h00, if8.resultado};
         co  = if8.c_out;    ov = if8.overflow; z = if8.zero;
      end else begin
         rdy = if16.ready;   v  = if16.valid;    r = if16.resultado;
         co  = if16.c_out;   ov = if16.overflow; z = if16.zero;
      end
   endtask

   // One full transaction; optionally re-pulses start during CALC
   task automatic applyStimulus(input int sel, input logic m,
                                input logic [15:0] ua, input logic [15:0] ub,
                                input bit glitch, input string tag);
      int          w, ndig, cycles;
      logic        got, rdy, v, co, ov, z;
      logic        eCo, eOv, eZ;
      logic [15:0] r, prevRes, eRes;
      w    = (sel == 0) ? 8 : 16;
      ndig = (sel == 0) ? 8 : 4;
      refModel(w, m, longint'(ua), longint'(ub), eRes, eCo, eOv, eZ);
      @(negedge clk);
      drive(sel, 1'b1, m, ua, ub);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      sampleOut(sel, rdy, v, prevRes, co, ov, z);
      cycles = 0;
      got    = 1'b0;
      while (!got && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         sampleOut(sel, rdy, v, r, co, ov, z);
         if (cycles == 2) checkOutput({tag, "_ready_busy"}, 32'(rdy), 32'd0);
         if (cycles == 3) begin
            checkOutput({tag, "_hold"}, 32'(r), 32'(prevRes));
            if (glitch) drive(sel, 1'b1, ~m, 16'($urandom), 16'($urandom));
         end
         if (cycles == 4 && glitch) drive(sel, 1'b0, m, ua, ub);
         if (v) got = 1'b1;
      end
      checkOutput({tag, "_valid_seen"}, 32'(got), 32'd1);
      if (got) begin
         checkOutput({tag, "_latency"}, 32'(cycles), 32'(ndig + 1));
         checkOutput({tag, "_resultado"}, 32'(r), 32'(eRes));
         checkOutput({tag, "_c_out"}, 32'(co), 32'(eCo));
         checkOutput({tag, "_overflow"}, 32'(ov), 32'(eOv));
         checkOutput({tag, "_zero"}, 32'(z), 32'(eZ));
         @(posedge clk);
         #1;
         sampleOut(sel, rdy, v, r, co, ov, z);
         checkOutput({tag, "_valid_pulse"}, 32'(v), 32'd0);
         checkOutput({tag, "_ready_after"}, 32'(rdy), 32'd1);
         checkOutput({tag, "_res_held"}, 32'(r), 32'(eRes));
      end
   endtask

   // Main sequence: reset, directed cases, handshake/reset abort, random ops
   initial begin
      logic        rdy, v, co, ov, z, sawValid;
      logic [15:0] r;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive(0, 1'b0, MODO_SUMA, 16'h0, 16'h0);
      drive(1, 1'b0, MODO_SUMA, 16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      sampleOut(0, rdy, v, r, co, ov, z);
      checkOutput("rst_ready", 32'(rdy), 32'd1);
      checkOutput("rst_valid", 32'(v), 32'd0);
      checkOutput("rst_resultado", 32'(r), 32'd0);
      checkOutput("rst_flags", {29'd0, co, ov, z}, 32'd0);
      sampleOut(1, rdy, v, r, co, ov, z);
      checkOutput("rst16_ready", 32'(rdy), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, MODO_RESTA, 16'h05, 16'h03, 1'b0, "sub_5_3");
      applyStimulus(0, MODO_RESTA, 16'h03, 16'h05, 1'b0, "sub_3_5");
      applyStimulus(0, MODO_RESTA, 16'h2A, 16'h2A, 1'b0, "sub_eq");
      applyStimulus(0, MODO_SUMA,  16'h7F, 16'h01, 1'b0, "add_ovf");
      applyStimulus(0, MODO_RESTA, 16'h80, 16'h01, 1'b0, "sub_ovf");
      applyStimulus(0, MODO_SUMA,  16'h11, 16'h22, 1'b1, "glitch");
      applyStimulus(1, MODO_SUMA,  16'hFFFF, 16'h0001, 1'b0, "w16_wrap");

      // Reset mid-CALC must clear outputs at once and suppress valid
      applyStimulus(0, MODO_RESTA, 16'h80, 16'h01, 1'b0, "pre_rst");
      @(negedge clk);
      drive(0, 1'b1, MODO_SUMA, 16'h33, 16'h44);
      @(posedge clk);
      #1;
      drive(0, 1'b0, MODO_SUMA, 16'h0, 16'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      sampleOut(0, rdy, v, r, co, ov, z);
      checkOutput("abort_ready", 32'(rdy), 32'd1);
      checkOutput("abort_valid", 32'(v), 32'd0);
      checkOutput("abort_resultado", 32'(r), 32'd0);
      checkOutput("abort_flags", {29'd0, co, ov, z}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      sawValid = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         sampleOut(0, rdy, v, r, co, ov, z);
         if (v) sawValid = 1'b1;
      end
      checkOutput("abort_no_valid", 32'(sawValid), 32'd0);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
                       16'($urandom_range(0, 255)), 1'b0, "rnd8");
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 65535)), 1'b0, "rnd16");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
